flash_arbiter: RTL

Shares the single dual-IO SPI flash byte reader between two requesters. Port A is the high-priority console ROM fetch path. Port B is the low-priority loader/streamer path. The block sequences the reader's edge-triggered cs/busy handshake, holds the address stable for the whole transfer, and keeps a one-entry read cache per port so repeated fetches do not touch the flash. It sits between the cartridge/loader logic and the flash reader.

---
 rtl/flash_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/flash_arbiter.sv
// flash_arbiter
// Shares one SPI flash byte reader between two requesters. Port A is the
// high-priority console ROM fetch path. Port B is the low-priority
// loader/streamer path. Each port has a one-entry read cache, so a repeated
// fetch of the same address is answered without touching the flash.
//
// Ports:
//   clk, resetn              system clock, asynchronous active-low reset
//   a_req/a_addr/a_ack/a_data  port A: level request, byte address,
//                              one-cycle ack pulse, read data (held)
//   b_req/b_addr/b_ack/b_data  port B: same as port A
//   inv                      invalidate both cache entries
//   flash_ready/busy/dout    reader status and read data
//   flash_addr/flash_cs      reader address (held for the whole transfer)
//                            and start strobe (reader acts on its rising edge)
//   active                   00 idle, 01 A owns flash, 10 B owns flash
module flash_arbiter #(
  parameter int STARVE_LIMIT  = 4,
  parameter int START_TIMEOUT = 15,
  parameter int GAP_CYCLES    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  output logic        a_ack,
  output logic [7:0]  a_data,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  output logic        b_ack,
  output logic [7:0]  b_data,
  input  logic        inv,
  input  logic        flash_ready,
  input  logic        flash_busy,
  input  logic [7:0]  flash_dout,
  output logic [23:0] flash_addr,
  output logic        flash_cs,
  output logic [1:0]  active
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [5:0] TMO_LAST   = 6'(START_TIMEOUT - 1);
  localparam logic [5:0] GAP_LAST   = 6'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t      state_q, state_d;
  logic [23:0] flash_addr_q, flash_addr_d;
  logic        flash_cs_q, flash_cs_d;
  logic [1:0]  active_q, active_d;
  logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [7:0]  a_data_q, a_data_d, b_data_q, b_data_d;
  logic [23:0] a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic [7:0]  a_cdata_q, a_cdata_d, b_cdata_q, b_cdata_d;
  logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [3:0]  starve_q, starve_d;
  logic [5:0]  tmo_q, tmo_d;
  logic [5:0]  gap_q, gap_d;

  logic a_match, b_match, a_hit, b_hit, a_miss, b_miss, grant_b;

  // A port is ineligible during its own ack cycle: the requester is still
  // presenting the old request while it reacts to the ack.
  assign a_match = a_valid_q && (a_addr == a_tag_q);
  assign b_match = b_valid_q && (b_addr == b_tag_q);
  assign a_hit   = a_req && !a_ack_q && a_match;
  assign b_hit   = b_req && !b_ack_q && b_match;
  assign a_miss  = a_req && !a_ack_q && !a_match;
  assign b_miss  = b_req && !b_ack_q && !b_match;
  assign grant_b = b_miss && (!a_miss || (starve_q >= STARVE_LIM));

  always_comb begin
    state_d      = state_q;
    flash_addr_d = flash_addr_q;
    flash_cs_d   = flash_cs_q;
    active_d     = active_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_data_d     = a_data_q;
    b_data_d     = b_data_q;
    a_tag_d      = a_tag_q;
    b_tag_d      = b_tag_q;
    a_cdata_d    = a_cdata_q;
    b_cdata_d    = b_cdata_q;
    a_valid_d    = a_valid_q;
    b_valid_d    = b_valid_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;

    // Cache hits are answered regardless of what the flash is doing.
    if (a_hit) begin
      a_ack_d  = 1'b1;
      a_data_d = a_cdata_q;
    end
    if (b_hit) begin
      b_ack_d  = 1'b1;
      b_data_d = b_cdata_q;
    end

    if (inv) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (flash_ready && (a_miss || b_miss)) begin
          flash_addr_d = grant_b ? b_addr : a_addr;
          active_d     = grant_b ? 2'b10 : 2'b01;
          flash_cs_d   = 1'b1;
          tmo_d        = '0;
          state_d      = START;
          if (grant_b) begin
            starve_d = '0;
          end else if (b_miss && (starve_q != 4'd15)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      START: begin
        if (flash_busy) begin
          flash_cs_d = 1'b0;
          state_d    = WAIT;
        end else if (tmo_q == TMO_LAST) begin
          // Reader never answered: drop cs long enough for its cs
          // synchroniser to see a low, then try again.
          flash_cs_d = 1'b0;
          gap_d      = '0;
          state_d    = GAP;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          flash_cs_d = 1'b1;
          tmo_d      = '0;
          state_d    = START;
        end else begin
          gap_d = gap_q + 6'd1;
        end
      end
      WAIT: begin
        // flash_addr_q is left untouched: the reader samples it mid-transfer.
        if (!flash_busy) begin
          // A fill coinciding with inv still delivers data but stays invalid.
          if (active_q[0]) begin
            a_data_d  = flash_dout;
            a_cdata_d = flash_dout;
            a_tag_d   = flash_addr_q;
            a_valid_d = !inv;
            a_ack_d   = 1'b1;
          end else begin
            b_data_d  = flash_dout;
            b_cdata_d = flash_dout;
            b_tag_d   = flash_addr_q;
            b_valid_d = !inv;
            b_ack_d   = 1'b1;
          end
          active_d = 2'b00;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      flash_addr_q <= '0;
      flash_cs_q   <= 1'b0;
      active_q     <= 2'b00;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_data_q     <= '0;
      b_data_q     <= '0;
      a_tag_q      <= '0;
      b_tag_q      <= '0;
      a_cdata_q    <= '0;
      b_cdata_q    <= '0;
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      starve_q     <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      flash_addr_q <= flash_addr_d;
      flash_cs_q   <= flash_cs_d;
      active_q     <= active_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_data_q     <= a_data_d;
      b_data_q     <= b_data_d;
      a_tag_q      <= a_tag_d;
      b_tag_q      <= b_tag_d;
      a_cdata_q    <= a_cdata_d;
      b_cdata_q    <= b_cdata_d;
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
    end
  end

  assign flash_addr = flash_addr_q;
  assign flash_cs   = flash_cs_q;
  assign active     = active_q;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_data     = a_data_q;
  assign b_data     = b_data_q;

endmodule
